posit_to_fp32_pipe: RTL

- Parametrised, pipelined converter from posit<N,ES> to IEEE-754 binary32. Generalises the combinational posit16 (es=0) to fp32 decoder.
- Adds generic N/ES, zero and NaR handling, round-to-nearest-even on truncated fractions, inexact/NaR flags, and a 2-stage valid/ready pipeline.
- Sits between the PPU posit register file read path and the fp32 export/debug interface.

---
 rtl/posit_to_fp32_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/posit_to_fp32_pipe.sv
// posit_to_fp32_pipe: two-stage valid/ready converter from posit<N,ES> to IEEE-754 binary32
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_posit input handshake;
// out_valid/out_ready output handshake with registered out_fp32, out_nar, out_inexact.
module posit_to_fp32_pipe #(
  parameter int N  = 16,
  parameter int ES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_posit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_fp32,
  output logic         out_nar,
  output logic         out_inexact
);
  localparam int F  = N - 3 - ES;
  localparam int FW = (F > 23) ? F : 23;
  localparam int RW = $clog2(N) + 1;
  if (N < 8 || N > 32 || ES < 0 || ES > 3 || ((N - 2) << ES) > 126) begin : g_bad_params
    $error("posit_to_fp32_pipe: unsupported N/ES combination");
  end
  logic s1_valid, s2_valid, s1_adv;
  logic s1_sign, s1_zero, s1_nar;
  logic [7:0] s1_scale;
  logic [F-1:0] s1_frac;
  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;
  logic sign, run;
  logic [N-2:0] rem;
  logic [N-4:0] tail;
  logic [RW-1:0] r;
  logic [3:0] e;
  logic [7:0] k, scale;
  // The regime is at least two bits (run + terminator), so the ES+fraction tail
  // is the low N-3 magnitude bits shifted up by the extra run length.
  always_comb begin
    sign = in_posit[N-1];
    rem  = (N-1)'(sign ? -in_posit : in_posit);
    r    = '0;
    run  = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      run = run & (rem[i] == rem[N-2]);
      r   = r + RW'(run);
    end
    tail  = rem[N-4:0] << (r - RW'(1));
    e     = 4'(tail >> F);
    k     = rem[N-2] ? 8'(r) - 8'd1 : -8'(r);
    scale = (k << ES) + 8'(e);
  end
  logic [FW-1:0] fa;
  logic [FW+1:0] fx;
  logic [22:0] kept;
  logic guard, sticky, rnd;
  logic [23:0] mant;
  logic [7:0] expo;
  // Scale always lands in [-127,127], so 8-bit wraparound arithmetic yields the biased exponent directly.
  always_comb begin
    fa     = FW'(s1_frac) << (FW - F);
    fx     = {fa, 2'b00};
    kept   = fx[FW+1 -: 23];
    guard  = fx[FW-22];
    sticky = |(fx << 24);
    rnd    = guard & (sticky | kept[0]);
    mant   = {1'b0, kept} + 24'(rnd);
    expo   = s1_scale + 8'd127 + 8'(mant[23]);
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign  <= sign;
      s1_zero  <= in_posit == '0;
      s1_nar   <= in_posit == {1'b1, {(N-1){1'b0}}};
      s1_scale <= scale;
      s1_frac  <= tail[F-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_fp32    <= '0;
      out_nar     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_adv) s2_valid <= s1_valid;
      if (s1_adv && s1_valid) begin
        out_fp32    <= s1_zero ? 32'h0 : s1_nar ? 32'h7FC00000 : {s1_sign, expo, mant[22:0]};
        out_nar     <= s1_nar;
        out_inexact <= !s1_zero && !s1_nar && (guard || sticky);
      end
    end
  end
endmodule
